// File: rtl/pwm_preconditioner_if.sv
// Sample stream into the preconditioner and committed rise/fall banks out of it.
// Member prefixes are from the preconditioner's point of view.
interface pwm_preconditioner_if #(
  parameter int WIDTH = 13,
  parameter int DEPTH = 249
);
  logic             i_din_valid;
  logic [WIDTH-1:0] i_cycle;
  logic [WIDTH-1:0] i_duty;
  logic [WIDTH-1:0] i_phase;
  logic [WIDTH-1:0] o_rise_out [DEPTH];
  logic [WIDTH-1:0] o_fall_out [DEPTH];
  logic             o_dout_valid;
  logic             o_busy;

  modport master (
    output i_din_valid, i_cycle, i_duty, i_phase,
    input  o_rise_out, o_fall_out, o_dout_valid, o_busy
  );

  modport slave (
    input  i_din_valid, i_cycle, i_duty, i_phase,
    output o_rise_out, o_fall_out, o_dout_valid, o_busy
  );
endinterface

// File: rtl/pwm_preconditioner.sv
// Converts per-channel duty/phase/cycle samples into wrapped rise/fall edge times,
// gathers a full frame in a shadow bank and commits it to the outputs in one cycle.
module pwm_preconditioner #(
  parameter int WIDTH = 13,
  parameter int DEPTH = 249
) (
  input  logic                i_clk,
  input  logic                i_rst_n,
  pwm_preconditioner_if.slave io_bus
);
  localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int SW = WIDTH + 2;
  localparam logic [IW-1:0] LAST_IDX = IW'(DEPTH - 1);

  typedef logic [WIDTH-1:0]        word_t;
  typedef logic signed [SW-1:0]    sword_t;

  logic          r_armed;
  logic          w_accept;
  logic [IW-1:0] r_idx;

  logic          r_s1_valid;
  logic [IW-1:0] r_s1_idx;
  word_t         r_s1_cycle, r_s1_duty, r_s1_phase;
  word_t         w_d, w_p, w_hlo, w_hhi;

  logic          r_s2_valid;
  logic [IW-1:0] r_s2_idx;
  word_t         r_s2_c, r_s2_d, r_s2_p, r_s2_hlo, r_s2_hhi;
  sword_t        w_r, w_f;

  logic          r_s3_valid;
  logic [IW-1:0] r_s3_idx;
  word_t         r_s3_c, r_s3_d;
  sword_t        r_s3_r, r_s3_f;
  sword_t        w_c_s, w_r_wrap, w_f_wrap;
  word_t         w_rise, w_fall;

  word_t         r_shadow_rise [DEPTH];
  word_t         r_shadow_fall [DEPTH];
  word_t         r_rise_out    [DEPTH];
  word_t         r_fall_out    [DEPTH];
  logic          r_commit_pend;
  logic          r_dout_valid;
  logic          r_busy;

  // The cycle straight after reset release is ignored while the external sync settles.
  assign w_accept = io_bus.i_din_valid & r_armed;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_armed <= 1'b0;
      r_idx   <= '0;
    end else begin
      r_armed <= 1'b1;
      if (w_accept) r_idx <= (r_idx == LAST_IDX) ? '0 : r_idx + IW'(1);
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_s1_valid <= 1'b0;
      r_s1_idx   <= '0;
      r_s1_cycle <= '0;
      r_s1_duty  <= '0;
      r_s1_phase <= '0;
    end else begin
      r_s1_valid <= w_accept;
      if (w_accept) begin
        r_s1_idx   <= r_idx;
        r_s1_cycle <= io_bus.i_cycle;
        r_s1_duty  <= io_bus.i_duty;
        r_s1_phase <= io_bus.i_phase;
      end
    end
  end

  assign w_d   = (r_s1_duty < r_s1_cycle) ? r_s1_duty : r_s1_cycle;
  assign w_p   = (r_s1_phase < r_s1_cycle) ? r_s1_phase : r_s1_cycle - word_t'(1);
  assign w_hlo = w_d >> 1;
  assign w_hhi = (w_d >> 1) + word_t'(w_d[0]);

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_s2_valid <= 1'b0;
      r_s2_idx   <= '0;
      r_s2_c     <= '0;
      r_s2_d     <= '0;
      r_s2_p     <= '0;
      r_s2_hlo   <= '0;
      r_s2_hhi   <= '0;
    end else begin
      r_s2_valid <= r_s1_valid;
      if (r_s1_valid) begin
        r_s2_idx <= r_s1_idx;
        r_s2_c   <= r_s1_cycle;
        r_s2_d   <= w_d;
        r_s2_p   <= w_p;
        r_s2_hlo <= w_hlo;
        r_s2_hhi <= w_hhi;
      end
    end
  end

  assign w_r = $signed({2'b00, r_s2_p}) - $signed({2'b00, r_s2_hlo});
  assign w_f = $signed({2'b00, r_s2_p}) + $signed({2'b00, r_s2_hhi});

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_s3_valid <= 1'b0;
      r_s3_idx   <= '0;
      r_s3_c     <= '0;
      r_s3_d     <= '0;
      r_s3_r     <= '0;
      r_s3_f     <= '0;
    end else begin
      r_s3_valid <= r_s2_valid;
      if (r_s2_valid) begin
        r_s3_idx <= r_s2_idx;
        r_s3_c   <= r_s2_c;
        r_s3_d   <= r_s2_d;
        r_s3_r   <= w_r;
        r_s3_f   <= w_f;
      end
    end
  end

  // Edges are at most one period out of range, so a single add/subtract wraps them.
  assign w_c_s    = $signed({2'b00, r_s3_c});
  assign w_r_wrap = (r_s3_r < sword_t'(0)) ? r_s3_r + w_c_s : r_s3_r;
  assign w_f_wrap = (r_s3_f >= w_c_s) ? r_s3_f - w_c_s : r_s3_f;

  // Zero duty (which also covers an illegal zero cycle) is always off; full duty always on.
  always_comb begin
    w_rise = '0;
    w_fall = '0;
    if (r_s3_d != '0) begin
      if (r_s3_d == r_s3_c) begin
        w_fall = r_s3_c;
      end else begin
        w_rise = word_t'(w_r_wrap);
        w_fall = word_t'(w_f_wrap);
      end
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_shadow_rise[i] <= '0;
        r_shadow_fall[i] <= '0;
      end
    end else if (r_s3_valid) begin
      r_shadow_rise[r_s3_idx] <= w_rise;
      r_shadow_fall[r_s3_idx] <= w_fall;
    end
  end

  // The copy reads the shadow before the next frame's channel 0 write can land on it.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_commit_pend <= 1'b0;
      r_dout_valid  <= 1'b0;
      r_busy        <= 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
        r_rise_out[i] <= '0;
        r_fall_out[i] <= '0;
      end
    end else begin
      r_commit_pend <= r_s3_valid && (r_s3_idx == LAST_IDX);
      r_dout_valid  <= r_commit_pend;
      if (r_commit_pend) begin
        r_rise_out <= r_shadow_rise;
        r_fall_out <= r_shadow_fall;
      end
      if (w_accept)
        r_busy <= 1'b1;
      else if (r_commit_pend)
        r_busy <= (r_idx != '0) | r_s1_valid | r_s2_valid | r_s3_valid;
    end
  end

  assign io_bus.o_rise_out   = r_rise_out;
  assign io_bus.o_fall_out   = r_fall_out;
  assign io_bus.o_dout_valid = r_dout_valid;
  assign io_bus.o_busy       = r_busy;
endmodule

// File: tb/tb_pwm_preconditioner.sv
// Table vectors from the edge rules, randomized gapped/back-to-back frames against
// an arithmetic reference, and a mid-frame reset.
module tb_pwm_preconditioner;
  localparam int WIDTH = 13;
  localparam int DEPTH = 249;

  typedef struct {
    int cycle;
    int duty;
    int phase;
    int expRise;
    int expFall;
  } vec_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  pwm_preconditioner_if #(.WIDTH(WIDTH), .DEPTH(DEPTH)) bus ();

  pwm_preconditioner #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .i_clk  (clk),
    .i_rst_n(rst_n),
    .io_bus (bus)
  );

  always #5 clk = ~clk;

  int compared = 0;
  int failed = 0;
  int pulses = 0;
  int frameC [DEPTH];
  int frameD [DEPTH];
  int frameP [DEPTH];
  int curRise [DEPTH];
  int curFall [DEPTH];
  int pendRise [DEPTH];
  int pendFall [DEPTH];
  int expRise [DEPTH];
  int expFall [DEPTH];
  int cdown = -1;
  int partial = 0;
  bit busyExp = 1'b0;

  always @(negedge clk) if (rst_n && bus.o_dout_valid) pulses++;

  // Edge times straight from the rules: clamp, centre the pulse, wrap modulo the period.
  function automatic void refEdges(input int c, input int d, input int p,
                                   output int rise, output int fall);
    int dd, pp;
    rise = 0;
    fall = 0;
    if (c == 0) return;
    dd = (d < c) ? d : c;
    pp = (p < c) ? p : c - 1;
    if (dd == 0) return;
    if (dd == c) begin
      fall = c;
      return;
    end
    rise = ((pp - dd / 2) % c + c) % c;
    fall = (pp + (dd + 1) / 2) % c;
  endfunction

  task automatic checkOutput(input string name, input int actual, input int expected);
    compared++;
    if (actual != expected) begin
      failed++;
      $display("[TB] FAIL %s: got %0d, want %0d (t=%0t)", name, actual, expected, $time);
    end
  endtask

  task automatic checkBank(input string name);
    int bad;
    bad = -1;
    for (int i = 0; i < DEPTH; i++)
      if (bad < 0 && (int'(bus.o_rise_out[i]) != expRise[i] || int'(bus.o_fall_out[i]) != expFall[i]))
        bad = i;
    compared++;
    if (bad >= 0) begin
      failed++;
      $display("[TB] FAIL %s ch%0d: got rise=%0d fall=%0d, want rise=%0d fall=%0d (t=%0t)",
               name, bad, bus.o_rise_out[bad], bus.o_fall_out[bad], expRise[bad], expFall[bad], $time);
    end
  endtask

  // One clock: update the frame/commit model from what was driven, then check everything.
  task automatic applyStimulus(input bit isLast);
    bit acc, expDv;
    acc = bus.i_din_valid;
    expDv = 1'b0;
    @(posedge clk);
    #1;
    if (cdown > 0) begin
      cdown--;
      if (cdown == 0) begin
        expDv = 1'b1;
        expRise = pendRise;
        expFall = pendFall;
        cdown = -1;
      end
    end
    if (acc) begin
      if (isLast) begin
        partial = 0;
        cdown = 4;
        pendRise = curRise;
        pendFall = curFall;
      end else begin
        partial++;
      end
    end
    if (acc) busyExp = 1'b1;
    else if (expDv) busyExp = (partial > 0);
    checkOutput("dout_valid", int'(bus.o_dout_valid), int'(expDv));
    checkOutput("busy", int'(bus.o_busy), int'(busyExp));
    checkBank("bank");
  endtask

  task automatic idleCycles(input int n);
    bus.i_din_valid = 1'b0;
    repeat (n) applyStimulus(1'b0);
  endtask

  task automatic sendFrame(input int count, input int gapMax);
    int gaps;
    for (int ch = 0; ch < count; ch++) begin
      gaps = (gapMax > 0) ? int'($urandom_range(0, gapMax)) : 0;
      for (int g = 0; g < gaps; g++) begin
        bus.i_din_valid = 1'b0;
        applyStimulus(1'b0);
      end
      bus.i_din_valid = 1'b1;
      bus.i_cycle = WIDTH'(frameC[ch]);
      bus.i_duty  = WIDTH'(frameD[ch]);
      bus.i_phase = WIDTH'(frameP[ch]);
      applyStimulus(ch == DEPTH - 1);
    end
  endtask

  task automatic randomFrame();
    int c;
    for (int ch = 0; ch < DEPTH; ch++) begin
      c = ($urandom_range(0, 19) == 0) ? 0 : int'($urandom_range(1, 8191));
      frameC[ch] = c;
      frameD[ch] = ($urandom_range(0, 7) == 0 || c == 0) ? int'($urandom_range(0, 8191))
                                                         : int'($urandom_range(0, c));
      frameP[ch] = ($urandom_range(0, 3) == 0 || c == 0) ? int'($urandom_range(0, 8191))
                                                         : int'($urandom_range(0, c - 1));
      refEdges(frameC[ch], frameD[ch], frameP[ch], curRise[ch], curFall[ch]);
    end
  endtask

  task automatic constFrame(input int c, input int d, input int p, input int r, input int f);
    for (int ch = 0; ch < DEPTH; ch++) begin
      frameC[ch] = c;
      frameD[ch] = d;
      frameP[ch] = p;
      curRise[ch] = r;
      curFall[ch] = f;
    end
  endtask

  initial begin
    vec_t vecs [7];
    int pulseBase;

    vecs[0] = '{4096, 100,  150,  100,  200};
    vecs[1] = '{4096, 101,  150,  100,  201};
    vecs[2] = '{4096, 100,  0,    4046, 50};
    vecs[3] = '{4096, 100,  4090, 4040, 44};
    vecs[4] = '{4096, 5000, 150,  0,    4096};
    vecs[5] = '{4096, 0,    150,  0,    0};
    vecs[6] = '{4096, 2,    5000, 4094, 0};

    for (int i = 0; i < DEPTH; i++) begin
      expRise[i] = 0;
      expFall[i] = 0;
    end
    bus.i_din_valid = 1'b0;
    bus.i_cycle = '0;
    bus.i_duty = '0;
    bus.i_phase = '0;

    repeat (2) @(posedge clk);
    #1;
    checkOutput("reset_dout_valid", int'(bus.o_dout_valid), 0);
    checkOutput("reset_busy", int'(bus.o_busy), 0);
    checkBank("reset_bank");
    rst_n = 1'b1;
    idleCycles(2);

    for (int v = 0; v < 7; v++) begin
      constFrame(vecs[v].cycle, vecs[v].duty, vecs[v].phase, vecs[v].expRise, vecs[v].expFall);
      sendFrame(DEPTH, 0);
      idleCycles(6);
    end

    // Gapped frame, then a contiguous frame with fresh values starting the very next cycle.
    pulseBase = pulses;
    randomFrame();
    sendFrame(DEPTH, 3);
    randomFrame();
    sendFrame(DEPTH, 0);
    idleCycles(6);
    checkOutput("pulse_count", pulses - pulseBase, 2);

    // Reset in the middle of a frame clears everything without waiting for a clock.
    constFrame(4096, 100, 150, 100, 200);
    sendFrame(100, 0);
    #2;
    rst_n = 1'b0;
    bus.i_din_valid = 1'b0;
    #1;
    for (int i = 0; i < DEPTH; i++) begin
      expRise[i] = 0;
      expFall[i] = 0;
    end
    cdown = -1;
    partial = 0;
    busyExp = 1'b0;
    checkOutput("midreset_dout_valid", int'(bus.o_dout_valid), 0);
    checkOutput("midreset_busy", int'(bus.o_busy), 0);
    checkBank("midreset_bank");
    idleCycles(2);
    rst_n = 1'b1;
    idleCycles(2);
    sendFrame(DEPTH, 0);
    idleCycles(6);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, failed);
    $finish;
  end
endmodule
